// File: rtl/product_accumulator_pkg.sv
// Shared types and width helpers for the product accumulator and the
// wrapper that chains multiplier -> product_accumulator.
package product_accumulator_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_e;

  // Widest possible sum of acc_len products needs log2(acc_len) growth bits.
  function automatic int calc_acc_width(int a_w, int b_w, int acc_len);
    return a_w + b_w + $clog2(acc_len);
  endfunction

  function automatic int calc_cnt_width(int acc_len);
    return $clog2(acc_len + 1);
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product input stream and result output stream of the accumulator.
// Both sides use valid/ready: a transfer happens on a rising clk edge where
// valid && ready; the sender holds data stable while valid && !ready.
interface product_accumulator_if #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8,
  parameter int ACC_LEN = 4
);
  import product_accumulator_pkg::*;

  localparam int P_WIDTH   = A_WIDTH + B_WIDTH;
  localparam int ACC_WIDTH = calc_acc_width(A_WIDTH, B_WIDTH, ACC_LEN);
  localparam int CNT_WIDTH = calc_cnt_width(ACC_LEN);

  logic                 prod_valid;
  logic                 prod_ready;
  logic [P_WIDTH-1:0]   prod;
  logic                 prod_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic [CNT_WIDTH-1:0] out_count;

  // master: product source and result sink (upstream/downstream side)
  modport master (
    output prod_valid, prod, prod_last, out_ready,
    input  prod_ready, out_valid, out_sum, out_count
  );

  // slave: the accumulator itself
  modport slave (
    input  prod_valid, prod, prod_last, out_ready,
    output prod_ready, out_valid, out_sum, out_count
  );

endinterface

// File: rtl/product_accumulator.sv
// Sums groups of up to ACC_LEN products (closed early by prod_last) and
// presents each group's sum and beat count on a valid/ready output.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8,
  parameter int ACC_LEN = 4,
  parameter int SIGNED  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  product_accumulator_if.slave     bus,
  output state_e                   o_state
);

  localparam int P_WIDTH   = A_WIDTH + B_WIDTH;
  localparam int ACC_WIDTH = calc_acc_width(A_WIDTH, B_WIDTH, ACC_LEN);
  localparam int CNT_WIDTH = calc_cnt_width(ACC_LEN);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ACC_LEN);

  state_e               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_out_valid;
  logic [ACC_WIDTH-1:0] r_out_sum;
  logic [CNT_WIDTH-1:0] r_out_count;

  logic                 w_prod_ready;
  logic                 w_accept;
  logic                 w_close;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH-1:0] w_sum;
  logic [CNT_WIDTH-1:0] w_cnt_next;

  // A pending result blocks new beats unless it is leaving on this edge.
  assign w_prod_ready = !r_out_valid || bus.out_ready;
  assign w_accept     = bus.prod_valid && w_prod_ready;

  always_comb begin
    w_ext = {ACC_WIDTH{(SIGNED != 0) && bus.prod[P_WIDTH-1]}};
    w_ext[P_WIDTH-1:0] = bus.prod;
  end

  assign w_sum      = (r_cnt == '0) ? w_ext : r_acc + w_ext;
  assign w_cnt_next = r_cnt + 1'b1;
  assign w_close    = bus.prod_last || (w_cnt_next == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
    end else begin
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      // A closing beat on the handshake edge overrides the drop above.
      if (w_accept) begin
        if (w_close) begin
          r_out_sum   <= w_sum;
          r_out_count <= w_cnt_next;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_state     <= S_IDLE;
        end else begin
          r_acc       <= w_sum;
          r_cnt       <= w_cnt_next;
          r_state     <= S_ACC;
        end
      end
    end
  end

  assign bus.prod_ready = w_prod_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_sum    = r_out_sum;
  assign bus.out_count  = r_out_count;
  assign o_state        = r_state;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator (A=4, B=4, ACC_LEN=4, SIGNED=1):
// directed scenarios followed by randomized groups, gaps and backpressure.
module tb_product_accumulator;
  import product_accumulator_pkg::*;

  localparam int A_W     = 4;
  localparam int B_W     = 4;
  localparam int ACC_LEN = 4;
  localparam int P_W     = A_W + B_W;
  localparam int ACC_W   = 10;
  localparam int CNT_W   = 3;
  localparam int RES_W   = ACC_W + CNT_W;

  logic   clk;
  logic   rst;
  state_e dbg_state;

  product_accumulator_if #(.A_WIDTH(A_W), .B_WIDTH(B_W), .ACC_LEN(ACC_LEN)) bus ();

  product_accumulator #(
    .A_WIDTH(A_W), .B_WIDTH(B_W), .ACC_LEN(ACC_LEN), .SIGNED(1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // out_ready driver: 0 = hold low, 1 = hold high, 2 = random per cycle
  int ready_mode = 1;
  always @(posedge clk) begin
    #1;
    bus.out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
  end

  // ---------------- scoreboard ----------------
  logic [RES_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  logic [ACC_W-1:0] last_sum;
  logic [CNT_W-1:0] last_count;

  int model_sum = 0;
  int model_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: a group is the running signed sum of its beats, emitted on
  // the ACC_LEN-th beat or on a beat marked last.
  task automatic model_accept(input logic [P_W-1:0] p, input logic last);
    int v;
    v = $signed(p);
    model_sum += v;
    model_cnt++;
    if (last || model_cnt == ACC_LEN) begin
      exp_q.push_back({ACC_W'(model_sum), CNT_W'(model_cnt)});
      model_sum = 0;
      model_cnt = 0;
    end
  endtask

  // Monitor: compare every cycle a result is shown; pop on handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result sum=%0h count=%0d", bus.out_sum, bus.out_count);
      end else begin
        check("result", 32'({bus.out_sum, bus.out_count}), 32'(exp_q[0]));
        if (bus.out_ready) begin
          last_sum   = bus.out_sum;
          last_count = bus.out_count;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [P_W-1:0] p, input logic last, output int waits);
    bit accepted;
    accepted = 0;
    waits = 0;
    bus.prod_valid = 1'b1;
    bus.prod       = p;
    bus.prod_last  = last;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (bus.prod_ready) begin
        model_accept(p, last);
        accepted = 1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=not_accepted expected=accepted prod=%0h", p);
    end
    bus.prod_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.prod      = P_W'($urandom);
      bus.prod_last = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    ready_mode = 1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    idle(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int wsum;
    rst = 1'b1;
    bus.prod_valid = 1'b0;
    bus.prod       = '0;
    bus.prod_last  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sum",   32'(bus.out_sum),   32'd0);
    check("rst_out_count", 32'(bus.out_count), 32'd0);
    check("rst_prod_ready", 32'(bus.prod_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // 1. basic group, no stalls, one-cycle latency
    wsum = 0;
    send(8'd3, 1'b0, w); wsum += w;
    send(8'd5, 1'b0, w); wsum += w;
    send(8'd7, 1'b0, w); wsum += w;
    check("s1_state_mid", 32'(dbg_state), 32'(S_ACC));
    send(8'd9, 1'b0, w); wsum += w;
    check("s1_no_stall", 32'(wsum), 32'd0);
    @(negedge clk);
    check("s1_latency_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    drain();
    check("s1_sum", 32'(last_sum), 32'd24);
    check("s1_count", 32'(last_count), 32'd4);

    // 2. signed extremes
    repeat (4) send(8'hFF, 1'b0, w);
    drain();
    check("s2_neg4", 32'(last_sum), 32'h3FC);
    repeat (4) send(8'h7F, 1'b0, w);
    drain();
    check("s2_508", 32'(last_sum), 32'h1FC);
    repeat (4) send(8'h80, 1'b0, w);
    drain();
    check("s2_neg512", 32'(last_sum), 32'h200);

    // 3. early close, then single-beat group
    send(8'd10, 1'b0, w);
    send(8'd20, 1'b1, w);
    drain();
    check("s3_sum", 32'(last_sum), 32'd30);
    check("s3_count", 32'(last_count), 32'd2);
    send(8'd6, 1'b1, w);
    drain();
    check("s3_single_sum", 32'(last_sum), 32'd6);
    check("s3_single_count", 32'(last_count), 32'd1);

    // 4. backpressure holds the result and blocks a waiting beat
    ready_mode = 0;
    idle(1);
    repeat (4) send(8'd1, 1'b0, w);
    bus.prod_valid = 1'b1;
    bus.prod       = 8'd2;
    bus.prod_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("s4_prod_ready_low", 32'(bus.prod_ready), 32'd0);
      check("s4_sum_stable", 32'(bus.out_sum), 32'd4);
      check("s4_count_stable", 32'(bus.out_count), 32'd4);
      @(posedge clk);
      #1;
    end
    ready_mode = 1;
    send(8'd2, 1'b1, w);
    @(negedge clk);
    check("s4_new_valid", 32'(bus.out_valid), 32'd1);
    check("s4_new_sum", 32'(bus.out_sum), 32'd2);
    @(posedge clk);
    #1;
    drain();

    // 5. closing beat on the same edge as a handshake
    send(8'd5, 1'b1, w);
    send(8'd7, 1'b1, w);
    check("s5_no_stall", 32'(w), 32'd0);
    @(negedge clk);
    check("s5_valid", 32'(bus.out_valid), 32'd1);
    check("s5_sum", 32'(bus.out_sum), 32'd7);
    check("s5_count", 32'(bus.out_count), 32'd1);
    @(posedge clk);
    #1;
    drain();

    // 6. asynchronous reset mid-group
    send(8'd50, 1'b0, w);
    send(8'd50, 1'b0, w);
    check("s6_state_acc", 32'(dbg_state), 32'(S_ACC));
    #3;
    rst = 1'b1;
    #1;
    check("s6_rst_valid", 32'(bus.out_valid), 32'd0);
    check("s6_rst_sum", 32'(bus.out_sum), 32'd0);
    check("s6_rst_count", 32'(bus.out_count), 32'd0);
    check("s6_rst_state", 32'(dbg_state), 32'(S_IDLE));
    exp_q.delete();
    model_sum = 0;
    model_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    send(8'd1, 1'b0, w);
    send(8'd2, 1'b0, w);
    send(8'd3, 1'b0, w);
    send(8'd4, 1'b0, w);
    drain();
    check("s6_sum", 32'(last_sum), 32'd10);
    check("s6_count", 32'(last_count), 32'd4);

    // 7. random beats, gaps, early closes and backpressure
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      idle($urandom_range(0, 2));
      send(P_W'($urandom), ($urandom_range(0, 3) == 0), w);
    end
    send(8'd0, 1'b1, w);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute bound in case any wait above misbehaves.
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
